// File: rtl/sort_buffer_engine_if.sv
// sort_buffer_engine_if: host-side bus of the sort buffer engine.
//   master : host (drives load/read/start/mode, observes rd_data/busy/done)
//   slave  : engine
// Signals: wr_en/wr_addr/wr_data (load), rd_addr/rd_data (registered read),
//          start/len/desc/signed_cmp (sort request), busy/done (status),
//          swap_count (only when SORT_STATS_EN is defined).
interface sort_buffer_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              desc;
  logic              signed_cmp;
  logic              busy;
  logic              done;
`ifdef SORT_STATS_EN
  logic [15:0]       swap_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, start, len, desc, signed_cmp,
    input  rd_data, busy, done, swap_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, start, len, desc, signed_cmp,
    output rd_data, busy, done, swap_count
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, start, len, desc, signed_cmp,
    input  rd_data, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, start, len, desc, signed_cmp,
    output rd_data, busy, done
  );
`endif
endinterface

// File: rtl/sort_buffer_engine.sv
// sort_buffer_engine: DEPTH x DATA_W register array with an in-place bubble
// sort (early exit), ascending/descending, signed/unsigned compare.
// Ports:
//   clk        system clock, rising edge
//   reset_all  asynchronous active-high reset
//   bus        sort_buffer_engine_if.slave (load, registered read, start/len/
//              desc/signed_cmp request, busy/done status)
// Optional: define SORT_STATS_EN to add the 16-bit saturating swap_count.
module sort_buffer_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset_all,
  sort_buffer_engine_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SCAN     = 2'd1,
    S_PASS_END = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              swapped_q, swapped_d;
  logic              desc_q, desc_d;
  logic              signed_q, signed_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
`ifdef SORT_STATS_EN
  logic [15:0]       swap_count_q, swap_count_d;
`endif

  logic [IDX_W-1:0]  i_nxt_c;
  logic [LEN_W-1:0]  len_eff_c;
  logic [DATA_W-1:0] a_c, b_c;
  logic              gt_c, lt_c, ooo_c;

  assign i_nxt_c = i_q + IDX_W'(1);

  // Requested length clamped to the array size.
  assign len_eff_c = (32'(bus.len) > DEPTH) ? LEN_W'(DEPTH) : bus.len;

  // Pair comparator for the current scan position, using the latched mode.
  always_comb begin
    a_c = mem_q[i_q];
    b_c = mem_q[i_nxt_c];
    if (signed_q) begin
      gt_c = $signed(a_c) > $signed(b_c);
      lt_c = $signed(a_c) < $signed(b_c);
    end else begin
      gt_c = a_c > b_c;
      lt_c = a_c < b_c;
    end
    ooo_c = desc_q ? lt_c : gt_c;
  end

  // Next-state, array update and status/read-port logic.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    i_d       = i_q;
    last_d    = last_q;
    swapped_d = swapped_q;
    desc_d    = desc_q;
    signed_d  = signed_q;
`ifdef SORT_STATS_EN
    swap_count_d = swap_count_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Write lands before a same-edge start so the sort sees the new word.
        if (bus.wr_en && (32'(bus.wr_addr) < DEPTH)) begin
          mem_d[IDX_W'(bus.wr_addr)] = bus.wr_data;
        end
        if (bus.start) begin
          desc_d   = bus.desc;
          signed_d = bus.signed_cmp;
`ifdef SORT_STATS_EN
          swap_count_d = 16'd0;
`endif
          if (len_eff_c <= LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            i_d       = '0;
            last_d    = IDX_W'(len_eff_c - LEN_W'(2));
            swapped_d = 1'b0;
            state_d   = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        // Strict compare: equal neighbours never swap, keeping the sort stable.
        if (ooo_c) begin
          mem_d[i_q]     = b_c;
          mem_d[i_nxt_c] = a_c;
          swapped_d      = 1'b1;
`ifdef SORT_STATS_EN
          if (swap_count_q != 16'hFFFF) begin
            swap_count_d = swap_count_q + 16'd1;
          end
`endif
        end
        if (i_q == last_q) begin
          state_d = S_PASS_END;
        end else begin
          i_d = i_nxt_c;
        end
      end

      S_PASS_END: begin
        // A pass with no swaps means the range is already ordered.
        if (!swapped_q || (last_q == '0)) begin
          state_d = S_DONE;
        end else begin
          last_d    = last_q - IDX_W'(1);
          i_d       = '0;
          swapped_d = 1'b0;
          state_d   = S_SCAN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    rd_data_d = (32'(bus.rd_addr) < DEPTH) ? mem_q[IDX_W'(bus.rd_addr)] : '0;
  end

  // State and datapath registers; reset abandons any sort in flight.
  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) begin
      state_q   <= S_IDLE;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      i_q       <= '0;
      last_q    <= '0;
      swapped_q <= 1'b0;
      desc_q    <= 1'b0;
      signed_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
`ifdef SORT_STATS_EN
      swap_count_q <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      i_q       <= i_d;
      last_q    <= last_d;
      swapped_q <= swapped_d;
      desc_q    <= desc_d;
      signed_q  <= signed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
`ifdef SORT_STATS_EN
      swap_count_q <= swap_count_d;
`endif
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
`ifdef SORT_STATS_EN
  assign bus.swap_count = swap_count_q;
`endif

endmodule

// File: tb/tb_sort_buffer_engine.sv
// Testbench for sort_buffer_engine (DATA_W=8, DEPTH=16, ADDR_W=5).
module tb_sort_buffer_engine;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic reset_all;
  always #5 clk = ~clk;

  sort_buffer_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  sort_buffer_engine #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset_all(reset_all),
    .bus      (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] model  [16];
  logic [7:0] rd_buf [16];
  int done_cyc, busy_cnt, done_cnt, exp_swaps;

  // ---------------- reference model ----------------
  function automatic int sval(logic [7:0] v, bit s);
    return (s && v[7]) ? int'(v) - 256 : int'(v);
  endfunction

  function automatic bit ooo(logic [7:0] a, logic [7:0] b, bit d, bit s);
    return d ? (sval(a, s) < sval(b, s)) : (sval(a, s) > sval(b, s));
  endfunction

  // Stable sort of the first min(l,16) model entries; swaps = inversion count.
  task automatic model_sort(input int l, input bit d, input bit s, output int swaps);
    int eff;
    int best;
    logic [7:0] q[$];
    eff = (l > 16) ? 16 : l;
    swaps = 0;
    for (int k = 0; k < eff; k++) q.push_back(model[k]);
    for (int i = 0; i < eff; i++)
      for (int j = i + 1; j < eff; j++)
        if (ooo(q[i], q[j], d, s)) swaps++;
    for (int k = 0; k < eff; k++) begin
      best = 0;
      for (int m = 1; m < q.size(); m++)
        if (ooo(q[best], q[m], d, s)) best = m;
      model[k] = q[best];
      q.delete(best);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    bus.start = 0; bus.len = '0; bus.desc = 0; bus.signed_cmp = 0;
  endtask

  task automatic write_word(input int a, input logic [7:0] d);
    bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 0;
  endtask

  task automatic load_model();
    for (int k = 0; k < 16; k++) write_word(k, model[k]);
  endtask

  task automatic read_all();
    for (int k = 0; k < 16; k++) begin
      bus.rd_addr = AW'(k);
      @(posedge clk); #1;
      rd_buf[k] = bus.rd_data;
    end
  endtask

  task automatic random_model(input int lo, input int hi);
    for (int k = 0; k < 16; k++) model[k] = 8'($urandom_range(hi, lo));
  endtask

  // Pulse start (optionally with a same-edge write); wait for done with a bound.
  task automatic run_sort(input int l, input bit d, input bit s,
                          input bit wr, input int wa, input logic [7:0] wd);
    bus.len = (AW+1)'(l); bus.desc = d; bus.signed_cmp = s; bus.start = 1;
    if (wr) begin bus.wr_en = 1; bus.wr_addr = AW'(wa); bus.wr_data = wd; end
    @(posedge clk); #1;
    bus.start = 0; bus.wr_en = 0;
    done_cyc = -1; busy_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 400; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (done_cyc >= 0 && !bus.busy) break;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
    // Out-of-range writes must be dropped.
    write_word(16, 8'h77);
    write_word(20, 8'h5A);
    for (int k = 0; k < 16; k++) model[k] = 8'h00;
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL reset_entry[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
  endtask

  task automatic test_reverse();
    for (int k = 0; k < 16; k++) model[k] = 8'(15 - k);
    load_model();
    model_sort(16, 0, 0, exp_swaps);
    run_sort(16, 0, 0, 0, 0, 8'h00);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL reverse_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc < 1 || done_cyc > 136) begin failures++; $display("FAIL reverse_latency got=%0d exp=1..136", done_cyc); end
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL reverse_entry[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
`ifdef SORT_STATS_EN
    checks++; if (bus.swap_count !== 16'(exp_swaps)) begin failures++; $display("FAIL reverse_swaps got=%0d exp=%0d", bus.swap_count, exp_swaps); end
`endif
  endtask

  task automatic test_signed();
    logic [7:0] orig [16];
    random_model(0, 255);
    model[0] = 8'h05; model[1] = 8'hFD; model[2] = 8'h00; model[3] = 8'h80; model[4] = 8'h07;
    orig = model;
    for (int pass = 0; pass < 2; pass++) begin
      model = orig;
      load_model();
      model_sort(5, 0, (pass == 0), exp_swaps);
      run_sort(5, 0, (pass == 0), 0, 0, 8'h00);
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL signed%0d_done_pulses got=%0d exp=1", pass, done_cnt); end
      read_all();
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL signed%0d_entry[%0d] got=%h exp=%h", pass, k, rd_buf[k], model[k]); end
      end
`ifdef SORT_STATS_EN
      checks++; if (bus.swap_count !== 16'(exp_swaps)) begin failures++; $display("FAIL signed%0d_swaps got=%0d exp=%0d", pass, bus.swap_count, exp_swaps); end
`endif
    end
  endtask

  task automatic test_presorted();
    random_model(0, 255);
    for (int k = 0; k < 8; k++) model[k] = 8'(k + 1);
    load_model();
    model_sort(8, 0, 0, exp_swaps);
    run_sort(8, 0, 0, 0, 0, 8'h00);
    checks++; if (done_cyc !== 9) begin failures++; $display("FAIL presorted_done_cycle got=%0d exp=9", done_cyc); end
    checks++; if (busy_cnt !== 9) begin failures++; $display("FAIL presorted_busy_cycles got=%0d exp=9", busy_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL presorted_done_pulses got=%0d exp=1", done_cnt); end
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL presorted_entry[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
`ifdef SORT_STATS_EN
    checks++; if (bus.swap_count !== 16'(exp_swaps)) begin failures++; $display("FAIL presorted_swaps got=%0d exp=%0d", bus.swap_count, exp_swaps); end
`endif
  endtask

  task automatic test_len_small();
    for (int l = 0; l < 2; l++) begin
      random_model(0, 255);
      load_model();
      model_sort(l, 0, 0, exp_swaps);
      run_sort(l, 0, 0, 0, 0, 8'h00);
      checks++; if (done_cyc !== 1) begin failures++; $display("FAIL len%0d_done_cycle got=%0d exp=1", l, done_cyc); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL len%0d_done_pulses got=%0d exp=1", l, done_cnt); end
      read_all();
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL len%0d_entry[%0d] got=%h exp=%h", l, k, rd_buf[k], model[k]); end
      end
    end
  endtask

  task automatic test_clamp();
    random_model(0, 255);
    load_model();
    model_sort(20, 0, 0, exp_swaps);
    run_sort(20, 0, 0, 0, 0, 8'h00);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL clamp_done_pulses got=%0d exp=1", done_cnt); end
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL clamp_entry[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
  endtask

  task automatic test_desc_stable();
    for (int k = 0; k < 16; k++) model[k] = 8'hAA;
    model[0] = 3; model[1] = 9; model[2] = 3; model[3] = 1; model[4] = 9;
    load_model();
    model_sort(5, 1, 0, exp_swaps);
    run_sort(5, 1, 0, 0, 0, 8'h00);
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL desc_entry[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
`ifdef SORT_STATS_EN
    checks++; if (bus.swap_count !== 16'(exp_swaps)) begin failures++; $display("FAIL desc_swaps got=%0d exp=%0d", bus.swap_count, exp_swaps); end
`endif
  endtask

  task automatic test_random();
    int l, eff, lim;
    bit d, s;
    for (int it = 0; it < 8; it++) begin
      if (it[0]) random_model(0, 255); else random_model(0, 7);
      l = $urandom_range(20, 0); d = 1'($urandom_range(1, 0)); s = 1'($urandom_range(1, 0));
      eff = (l > 16) ? 16 : l;
      lim = (eff <= 1) ? 1 : ((eff - 1) * eff / 2 + (eff - 1) + 1);
      load_model();
      model_sort(l, d, s, exp_swaps);
      run_sort(l, d, s, 0, 0, 8'h00);
      checks++; if (done_cyc < 1 || done_cyc > lim) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=1..%0d", it, done_cyc, lim); end
      read_all();
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL rand%0d_entry[%0d] got=%h exp=%h (len=%0d desc=%0b sgn=%0b)", it, k, rd_buf[k], model[k], l, d, s); end
      end
`ifdef SORT_STATS_EN
      checks++; if (bus.swap_count !== 16'(exp_swaps)) begin failures++; $display("FAIL rand%0d_swaps got=%0d exp=%0d", it, bus.swap_count, exp_swaps); end
`endif
    end
  endtask

  // Same-edge write+start, then a second sort started right after the first.
  task automatic test_back_to_back();
    int wa;
    logic [7:0] wd;
    random_model(0, 255);
    load_model();
    wa = $urandom_range(15, 0); wd = 8'($urandom_range(255, 0));
    model[wa] = wd;
    model_sort(16, 0, 0, exp_swaps);
    run_sort(16, 0, 0, 1, wa, wd);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL b2b_first_done_pulses got=%0d exp=1", done_cnt); end
    model_sort(12, 1, 1, exp_swaps);
    run_sort(12, 1, 1, 0, 0, 8'h00);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL b2b_second_done_pulses got=%0d exp=1", done_cnt); end
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL b2b_entry[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
  endtask

  task automatic test_abuse();
    random_model(1, 255);
    load_model();
    model_sort(16, 0, 0, exp_swaps);
    bus.len = 6'd16; bus.desc = 0; bus.signed_cmp = 0; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    done_cyc = -1; done_cnt = 0;
    for (int c = 1; c <= 400; c++) begin
      if (c == 3) begin
        bus.wr_en = 1; bus.wr_addr = '0; bus.wr_data = 8'h00;
        bus.start = 1; bus.desc = 1; bus.signed_cmp = 1; bus.rd_addr = 5'd16;
      end else if (c == 4) begin
        checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL abuse_oob_read got=%h exp=00", bus.rd_data); end
        bus.wr_en = 0; bus.start = 0;
      end
      if (c == 8) bus.desc = 0;
      if (c == 12) bus.desc = 1;
      if (bus.done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (done_cyc >= 0 && !bus.busy) break;
      @(posedge clk); #1;
    end
    bus.desc = 0; bus.signed_cmp = 0;
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL abuse_done_pulses got=%0d exp=1", done_cnt); end
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL abuse_entry[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
`ifdef SORT_STATS_EN
    checks++; if (bus.swap_count !== 16'(exp_swaps)) begin failures++; $display("FAIL abuse_swaps got=%0d exp=%0d", bus.swap_count, exp_swaps); end
`endif
  endtask

  task automatic test_reset_midsort();
    for (int k = 0; k < 16; k++) model[k] = 8'(15 - k);
    load_model();
    bus.rd_addr = 5'd15;
    bus.len = 6'd16; bus.desc = 0; bus.signed_cmp = 0; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (19) begin @(posedge clk); #1; end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midsort_busy_before got=%0b exp=1", bus.busy); end
    #2 reset_all = 1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midsort_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midsort_done got=%0b exp=0", bus.done); end
    checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL midsort_rd_data got=%h exp=00", bus.rd_data); end
    #1 reset_all = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) model[k] = 8'h00;
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL midsort_cleared[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
    random_model(0, 255);
    load_model();
    model_sort(16, 1, 1, exp_swaps);
    run_sort(16, 1, 1, 0, 0, 8'h00);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL midsort_resort_done_pulses got=%0d exp=1", done_cnt); end
    read_all();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rd_buf[k] !== model[k]) begin failures++; $display("FAIL midsort_resort[%0d] got=%h exp=%h", k, rd_buf[k], model[k]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_all = 1;
    repeat (2) @(posedge clk);
    #1 reset_all = 0;
    test_reset();
    test_reverse();
    test_signed();
    test_presorted();
    test_len_small();
    test_clamp();
    test_desc_stable();
    test_random();
    test_back_to_back();
    test_abuse();
    test_reset_midsort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sort_buffer_engine.md
Name: sort_buffer_engine

Overview:
- Parametrised, self-contained sorting unit; successor to the datapath's sort mode, which addresses data memory externally through a 4-bit location index.
- Holds DEPTH words of DATA_W bits in an internal register array.
- Host loads the array, pulses start, and the block performs an in-place bubble sort with early exit. Ascending or descending; signed or unsigned compare.
- Host reads results through a registered read port; start/busy/done handshake to the control FSM.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 16, number of entries; must satisfy DEPTH <= 2**ADDR_W and DEPTH >= 2.
- ADDR_W, 4, address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_all  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe; honoured only in IDLE.
- wr_addr  input  ADDR_W  write index.
- wr_data  input  DATA_W  write word.
- rd_addr  input  ADDR_W  read index.
- rd_data  output  DATA_W  registered read data.
- start  input  1  sort request; sampled only in IDLE.
- len  input  ADDR_W+1  number of leading entries to sort; values above DEPTH clamp to DEPTH.
- desc  input  1  1 = descending, 0 = ascending; latched at start.
- signed_cmp  input  1  1 = two's-complement compare; latched at start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the sort completes.

Behaviour:
- Reset (async, any state, including mid-sort): all entries 0, state IDLE, rd_data 0, busy 0, done 0, internal counters 0. An aborted sort is not resumed.
- States: IDLE, SCAN, PASS_END, DONE. Cycle k is the period following clock edge k; the start-sampling edge is edge 0.
- IDLE:
  - wr_en with wr_addr < DEPTH writes the entry; wr_addr >= DEPTH is ignored.
  - start=1: latch len (clamped), desc and signed_cmp.
  - len <= 1: go to DONE.
  - Otherwise set i=0, last=len-2, swapped=0 and go to SCAN.
  - wr_en and start on the same edge: the write lands first, start is accepted, and the sort sees the new word.
- SCAN: one pair per cycle.
  - Compare buf[i] and buf[i+1]. Out of order means a > b for ascending, a < b for descending.
  - If out of order: swap both entries in the same edge and set swapped=1. Equal values never swap (stable).
  - If i == last, go to PASS_END; otherwise increment i.
- PASS_END:
  - If swapped=0 or last=0, go to DONE.
  - Otherwise decrement last, clear i and swapped, and return to SCAN.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing for already-sorted input of length L >= 2: SCAN in cycles 1..L-1, PASS_END in cycle L, done in cycle L+1. busy is high in cycles 1..L+1.
- Worst-case cycle count is bounded by (L-1)·L/2 + (L-1) + 1.
- Entries at index >= len are never modified.
- start, wr_en and changes to desc/signed_cmp while busy are ignored. The latched mode holds for the whole sort.
- rd_data <= buf[rd_addr] every edge in all states, so it reflects mid-sort contents. rd_addr >= DEPTH returns 0. Read latency is 1 cycle.

Optional Feature:
- Macro SORT_STATS_EN.
- Defined:
  - Adds output swap_count, 16 bits.
  - Cleared to 0 on start acceptance and on reset.
  - Increments by 1 per swap; saturates at 0xFFFF.
  - Holds its value after done until the next accepted start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reverse input: write 15..0 to entries 0..15, len=16, desc=0, signed_cmp=0, pulse start → done pulse once; reads give 0..15; swap_count=120 (SORT_STATS_EN).
- Signed vs unsigned, DATA_W=8: entries {5, 0xFD, 0, 0x80, 7}, len=5:
  - signed_cmp=1, ascending → 0x80, 0xFD, 0, 5, 7.
  - Same load, signed_cmp=0 → 0, 5, 7, 0x80, 0xFD.
- Presorted len=8 (values 1..8), ascending → busy in cycles 1..9, done only in cycle 9, swap_count=0, contents unchanged.
- Boundaries:
  - len=0 → done in cycle 1, no entry changes.
  - len=1 → done in cycle 1, no entry changes.
  - len=20 with DEPTH=16 → clamped; all 16 entries sorted.
  - Descending, len=5, entries {3,9,3,1,9} with entries 5..15 preset to 0xAA → {9,9,3,3,1}; entries 5..15 remain 0xAA.
- Handshake abuse during a sort:
  - wr_en to index 0 and a second start pulse while busy → both ignored; final result matches an undisturbed run.
  - Toggling desc mid-sort → no effect.
  - Read of rd_addr=16 → 0.
- Reset mid-sort: assert reset_all asynchronously in cycle 20 of a reverse-input sort → busy, done and rd_data drop to 0 immediately; all entries read 0 after release; the next start with fresh data sorts correctly.
